// File: rtl/sub_m.sv
// rtl/sub_m.sv - registered lane-wise signed subtractor with vector overflow flag
module sub_m #(
    parameter int LANE_W = 8,
    parameter int LANES  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*LANE_W-1:0]   m1,
    input  logic [LANES*LANE_W-1:0]   m2,
    output logic [LANES*LANE_W-1:0]   m_out,
    output logic                      ovf
);

    // Per-lane wrapped differences, packed the same way as the operands.
    logic [LANES*LANE_W-1:0] diff;
    // One overflow indication per lane.
    logic [LANES-1:0]        lane_ovf;

    // Each lane is an independent LANE_W-bit subtractor; slicing the operands
    // per lane guarantees no borrow crosses a lane boundary.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LANE_W-1:0] a;
        logic [LANE_W-1:0] b;
        logic [LANE_W-1:0] d;

        assign a = m1[k*LANE_W +: LANE_W];
        assign b = m2[k*LANE_W +: LANE_W];
        // Keeping only LANE_W bits gives modulo-2^LANE_W wrap, no saturation.
        assign d = a - b;
        assign diff[k*LANE_W +: LANE_W] = d;
        // Subtraction overflows only when the operand signs differ and the
        // result sign no longer matches the minuend sign.
        assign lane_ovf[k] = (a[LANE_W-1] ^ b[LANE_W-1]) & (d[LANE_W-1] ^ a[LANE_W-1]);
    end

    // Output register: one cycle latency, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out <= '0;
            ovf   <= 1'b0;
        end else begin
            m_out <= diff;
            ovf   <= |lane_ovf;
        end
    end

endmodule

// File: tb/tb_sub_m.sv
// tb/tb_sub_m.sv - randomized self-checking bench for sub_m
module tb_sub_m;

    localparam int LANE_W = 8;
    localparam int LANES  = 5;
    localparam int W      = LANE_W * LANES;

    logic         clk;
    logic         rst;
    logic [W-1:0] m1;
    logic [W-1:0] m2;
    logic [W-1:0] m_out;
    logic         ovf;

    int checks;
    int errors;

    sub_m #(.LANE_W(LANE_W), .LANES(LANES)) dut (
        .clk   (clk),
        .rst   (rst),
        .m1    (m1),
        .m2    (m2),
        .m_out (m_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer difference per lane, then wrap and range test.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic o);
        r = '0;
        o = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            int x;
            int y;
            int e;
            x = $signed(a[k*LANE_W +: LANE_W]);
            y = $signed(b[k*LANE_W +: LANE_W]);
            e = x - y;
            r[k*LANE_W +: LANE_W] = e[LANE_W-1:0];
            if (e < -128 || e > 127) o = 1'b1;
        end
    endtask

    function automatic logic [W-1:0] pack5(input int l4, input int l3, input int l2,
                                           input int l1, input int l0);
        logic [7:0] b4, b3, b2, b1, b0;
        b4 = l4[7:0]; b3 = l3[7:0]; b2 = l2[7:0]; b1 = l1[7:0]; b0 = l0[7:0];
        return {b4, b3, b2, b1, b0};
    endfunction

    // Drive operands at negedge, sample one edge later, compare with constants.
    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_out, input logic exp_ovf);
        @(negedge clk);
        m1 = a;
        m2 = b;
        @(posedge clk);
        #1;
        check({tag, "_out"}, m_out, exp_out);
        check({tag, "_ovf"}, ovf, exp_ovf);
    endtask

    initial begin
        logic [W-1:0] ra, rb, er;
        logic         eo;
        checks = 0;
        errors = 0;

        // Reset held with arbitrary operands and a running clock.
        rst = 1'b1;
        m1  = {$urandom, $urandom};
        m2  = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", m_out, '0);
        check("rst_ovf", ovf, 1'b0);

        // Release between edges; nothing appears until the next edge.
        @(negedge clk);
        m1 = pack5(50, 40, 30, 20, 10);
        m2 = pack5(45, 35, 25, 15, 5);
        rst = 1'b0;
        #1;
        check("post_rst_hold_out", m_out, '0);
        @(posedge clk);
        #1;
        check("first_edge_out", m_out, 40'h0505050505);
        check("first_edge_ovf", ovf, 1'b0);

        directed("mixed", pack5(50, -40, 30, -20, 10), pack5(-45, 35, -25, 15, -5),
                 40'h5FB537DD0F, 1'b0);
        directed("wrap2", pack5(50, -128, 127, -100, 100), pack5(-100, -1, 1, 30, 30),
                 40'h96817E7E46, 1'b1);
        directed("iso", 40'h0000800000, 40'h0000010000, 40'h00007F0000, 1'b1);

        // Boundary cases, each in a different lane with zeros elsewhere.
        directed("b_min_m1", pack5(0, 0, 0, 0, -128), pack5(0, 0, 0, 0, 1),
                 pack5(0, 0, 0, 0, 127), 1'b1);
        directed("b_max_mm1", pack5(0, 0, 0, 127, 0), pack5(0, 0, 0, -1, 0),
                 pack5(0, 0, 0, -128, 0), 1'b1);
        directed("b_min_min", pack5(0, 0, -128, 0, 0), pack5(0, 0, -128, 0, 0),
                 '0, 1'b0);
        directed("b_x_x", pack5(-77, 99, 3, -1, 127), pack5(-77, 99, 3, -1, 127),
                 '0, 1'b0);
        directed("b_min_mm1", pack5(-128, 0, 0, 0, 0), pack5(-1, 0, 0, 0, 0),
                 pack5(-127, 0, 0, 0, 0), 1'b0);

        // Randomized back-to-back stream with occasional async reset pulses.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rb[7:0] = 8'h80;
            m1 = ra;
            m2 = rb;
            model(ra, rb, er, eo);
            @(posedge clk);
            #1;
            check("rand_out", m_out, er);
            check("rand_ovf", ovf, eo);
            if ($urandom_range(0, 99) == 0) begin
                #1;
                rst = 1'b1;
                #1;
                check("async_rst_out", m_out, '0);
                check("async_rst_ovf", ovf, 1'b0);
                #1;
                rst = 1'b0;
            end
        end

        // A guaranteed mid-stream reset pulse between edges.
        @(negedge clk);
        m1 = pack5(127, 0, 0, 0, 0);
        m2 = pack5(-1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out", m_out, '0);
        check("mid_rst_ovf", ovf, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_rst_out", m_out, pack5(-128, 0, 0, 0, 0));
        check("after_rst_ovf", ovf, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_m.md
SUB_M -- requirements
Module: sub_m

Interface
REQ-001 Parameter LANE_W, default 8: width in bits of one signed element.
REQ-002 Parameter LANES, default 5: number of elements packed in one operand vector.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 m1  input  40 (LANES*LANE_W)  minuend vector; five signed two's-complement 8-bit elements.
REQ-006 m2  input  40  subtrahend vector; same packing as m1.
REQ-007 m_out  output  40  registered difference vector; same packing as m1.
REQ-008 ovf  output  1  registered overflow flag for the whole vector.

Function
REQ-009 Lane k (k = 0..4) SHALL occupy bits [8k+7:8k] of m1, m2 and m_out; lane 4 is bits [39:32], lane 0 is bits [7:0].
REQ-010 Each lane SHALL compute m_out[k] = m1[k] - m2[k] as signed 8-bit two's-complement arithmetic, independently of all other lanes.
REQ-011 No borrow or carry SHALL propagate across lane boundaries.
REQ-012 A lane result outside -128..127 SHALL wrap modulo 256: the stored value is the low 8 bits of the exact difference, with no saturation.
REQ-013 Lane overflow SHALL be detected as: operand signs differ and the result sign differs from the m1 sign; equivalently, the 9-bit exact difference is not representable in 8 bits.
REQ-014 ovf SHALL be the OR of all five lane overflow indications for the same operands that produce m_out.
REQ-015 m_out and ovf SHALL be registered and update on every rising clk edge while rst is low: one cycle of latency, no enable and no handshake.
REQ-016 Inputs applied before edge N SHALL be reflected in m_out and ovf immediately after edge N, and held until the next edge.
REQ-017 Back-to-back operand changes SHALL be processed every cycle, with full throughput.
REQ-018 Boundary cases SHALL follow REQ-012 and REQ-013 exactly:
 - -128 - 1 gives 127 with overflow.
 - 127 - (-1) gives -128 with overflow.
 - -128 - (-128) gives 0 with no overflow.
 - x - x gives 0 with no overflow.
 - -128 - (-1) gives -127 with no overflow.
REQ-019 The design SHALL contain no other state; the output depends only on the operands sampled at the last edge.

Reset
REQ-020 While rst is high, m_out SHALL be 40'h0 and ovf SHALL be 0, asynchronously, regardless of clk.
REQ-021 rst asserted mid-operation SHALL clear the outputs immediately, with no pending result surviving.
REQ-022 After rst deasserts, the first rising edge SHALL register the current operands normally.

Verification
REQ-023 rst=1 with arbitrary m1/m2, clock running -> m_out=0, ovf=0; deassert rst -> results appear after the next edge.
REQ-024 m1=[50,40,30,20,10], m2=[45,35,25,15,5] (lane 4 first) -> m_out=[5,5,5,5,5] = 40'h0505050505, ovf=0.
REQ-025 m1=[50,-40,30,-20,10], m2=[-45,35,-25,15,-5] -> m_out=[95,-75,55,-35,15] = 40'h5FB537DD0F, ovf=0.
REQ-026 m1=[50,-128,127,-100,100], m2=[-100,-1,1,30,30] -> m_out=[-106,-127,126,126,70] = 40'h96817E7E46, ovf=1 (lanes 4 and 1 wrap).
REQ-027 Single-lane overflow isolation: m1=40'h0000800000, m2=40'h0000010000 -> m_out=40'h00007F0000, ovf=1, with no disturbance to neighbouring lanes.
REQ-028 Randomized back-to-back vectors for at least 1000 cycles:
 - m_out and ovf SHALL match a per-lane reference model with one-cycle latency.
 - rst SHALL be pulsed asynchronously mid-stream, and the outputs SHALL clear at once.
